// File: rtl/read_stack_pop_seq.sv
// Stack pop sequencer: reads 1..MAX_POPS elements from SS:ESP with per-element
// SS limit checking, returning each element and the final ESP.
module read_stack_pop_seq #(
  parameter int unsigned MAX_POPS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pop_start,
  input  logic        pop_abort,
  input  logic [2:0]  pop_count,
  input  logic        pop_length_word,
  input  logic        pop_length_dword,
  input  logic        operand_16bit,
  input  logic [31:0] esp,
  input  logic [63:0] ss_cache,
  input  logic [31:0] ss_base,
  input  logic [31:0] ss_limit,
  output logic        rd_req,
  output logic [31:0] rd_linear,
  output logic [2:0]  rd_length,
  input  logic        rd_done,
  input  logic [31:0] rd_data,
  output logic [31:0] pop_data,
  output logic        pop_data_valid,
  output logic [2:0]  pop_index,
  output logic        pop_busy,
  output logic        pop_done,
  output logic        pop_ss_fault,
  output logic [31:0] pop_new_esp
);

  typedef enum logic [2:0] {IDLE, CHECK, READ, DONE, FAULT} state_e;

  localparam logic [2:0] MAX_CNT = 3'(MAX_POPS);

  state_e      state_q, state_d;
  logic [31:0] esp_q, esp_d;
  logic [31:0] base_q, base_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] off_q, off_d;
  logic        db_q, db_d;
  logic        ed_q, ed_d;
  logic        len4_q, len4_d;
  logic [2:0]  count_q, count_d;
  logic [2:0]  index_q, index_d;
  logic [31:0] pop_data_q, pop_data_d;
  logic        pop_data_valid_q, pop_data_valid_d;
  logic [2:0]  pop_index_q, pop_index_d;
  logic [31:0] new_esp_q, new_esp_d;

  logic [2:0]  len;
  logic [31:0] len_m1;
  logic [31:0] upper;
  logic        fault;
  logic [31:0] off_inc;
  logic [31:0] off_next;
  logic        start_len4;
  logic [2:0]  start_count;
  logic        unused_ss_bits;

  assign unused_ss_bits = ^{ss_cache[63:55], ss_cache[53:44], ss_cache[41:0]};

  always_comb begin
    len         = len4_q ? 3'd4 : 3'd2;
    len_m1      = {29'd0, len} - 32'd1;
    upper       = db_q ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    // Expand-down segments hold valid offsets strictly above the limit.
    if (ed_q) begin
      fault = (off_q <= limit_q) || (off_q > upper) || ((upper - off_q) < len_m1);
    end else begin
      fault = (off_q > limit_q) || ((limit_q - off_q) < len_m1);
    end
    off_inc     = off_q + {29'd0, len};
    off_next    = db_q ? off_inc : {16'h0000, off_inc[15:0]};
    start_len4  = ~(pop_length_word | (~pop_length_dword & operand_16bit));
    start_count = (pop_count > MAX_CNT) ? MAX_CNT : pop_count;
  end

  always_comb begin
    state_d          = state_q;
    esp_d            = esp_q;
    base_d           = base_q;
    limit_d          = limit_q;
    off_d            = off_q;
    db_d             = db_q;
    ed_d             = ed_q;
    len4_d           = len4_q;
    count_d          = count_q;
    index_d          = index_q;
    pop_data_d       = pop_data_q;
    pop_data_valid_d = 1'b0;
    pop_index_d      = pop_index_q;
    new_esp_d        = new_esp_q;

    if (pop_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop_start) begin
            esp_d   = esp;
            base_d  = ss_base;
            limit_d = ss_limit;
            db_d    = ss_cache[54];
            ed_d    = ss_cache[42] & ~ss_cache[43];
            len4_d  = start_len4;
            count_d = start_count;
            index_d = 3'd0;
            off_d   = ss_cache[54] ? esp : {16'h0000, esp[15:0]};
            if (start_count == 3'd0) begin
              state_d   = DONE;
              new_esp_d = esp;
            end else begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (fault) begin
            state_d   = FAULT;
            new_esp_d = esp_q;
          end else begin
            state_d = READ;
          end
        end
        READ: begin
          if (rd_done) begin
            pop_data_d       = len4_q ? rd_data : {16'h0000, rd_data[15:0]};
            pop_data_valid_d = 1'b1;
            pop_index_d      = index_q;
            off_d            = off_next;
            index_d          = index_q + 3'd1;
            if (index_q == count_q - 3'd1) begin
              state_d   = DONE;
              new_esp_d = db_q ? off_next : {esp_q[31:16], off_next[15:0]};
            end else begin
              state_d = CHECK;
            end
          end
        end
        DONE:    state_d = IDLE;
        FAULT:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      esp_q            <= '0;
      base_q           <= '0;
      limit_q          <= '0;
      off_q            <= '0;
      db_q             <= 1'b0;
      ed_q             <= 1'b0;
      len4_q           <= 1'b0;
      count_q          <= '0;
      index_q          <= '0;
      pop_data_q       <= '0;
      pop_data_valid_q <= 1'b0;
      pop_index_q      <= '0;
      new_esp_q        <= '0;
    end else begin
      state_q          <= state_d;
      esp_q            <= esp_d;
      base_q           <= base_d;
      limit_q          <= limit_d;
      off_q            <= off_d;
      db_q             <= db_d;
      ed_q             <= ed_d;
      len4_q           <= len4_d;
      count_q          <= count_d;
      index_q          <= index_d;
      pop_data_q       <= pop_data_d;
      pop_data_valid_q <= pop_data_valid_d;
      pop_index_q      <= pop_index_d;
      new_esp_q        <= new_esp_d;
    end
  end

  assign rd_req         = (state_q == READ);
  assign rd_linear      = rd_req ? (base_q + off_q) : '0;
  assign rd_length      = rd_req ? len : '0;
  assign pop_data       = pop_data_q;
  assign pop_data_valid = pop_data_valid_q;
  assign pop_index      = pop_index_q;
  assign pop_busy       = (state_q != IDLE);
  assign pop_done       = (state_q == DONE);
  assign pop_ss_fault   = (state_q == FAULT);
  assign pop_new_esp    = new_esp_q;

endmodule

// File: tb/tb_read_stack_pop_seq.sv
// Self-checking bench for read_stack_pop_seq: table of pop sequences with an
// address/data scoreboard, plus hand-written abort and reset sequences.
module tb_read_stack_pop_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pop_start, pop_abort;
  logic [2:0]  pop_count;
  logic        pop_length_word, pop_length_dword, operand_16bit;
  logic [31:0] esp;
  logic [63:0] ss_cache;
  logic [31:0] ss_base, ss_limit;
  logic        rd_req;
  logic [31:0] rd_linear;
  logic [2:0]  rd_length;
  logic        rd_done;
  logic [31:0] rd_data;
  logic [31:0] pop_data;
  logic        pop_data_valid;
  logic [2:0]  pop_index;
  logic        pop_busy, pop_done, pop_ss_fault;
  logic [31:0] pop_new_esp;

  read_stack_pop_seq #(.MAX_POPS(6)) dut (
    .clk(clk), .rst_n(rst_n), .pop_start(pop_start), .pop_abort(pop_abort),
    .pop_count(pop_count), .pop_length_word(pop_length_word),
    .pop_length_dword(pop_length_dword), .operand_16bit(operand_16bit),
    .esp(esp), .ss_cache(ss_cache), .ss_base(ss_base), .ss_limit(ss_limit),
    .rd_req(rd_req), .rd_linear(rd_linear), .rd_length(rd_length),
    .rd_done(rd_done), .rd_data(rd_data), .pop_data(pop_data),
    .pop_data_valid(pop_data_valid), .pop_index(pop_index),
    .pop_busy(pop_busy), .pop_done(pop_done), .pop_ss_fault(pop_ss_fault),
    .pop_new_esp(pop_new_esp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        db, code, ed;
    logic [31:0] esp, base, limit;
    logic [2:0]  count;
    logic        word, dword, op16;
    logic        restart;
    int          n_reads;
    logic        exp_fault;
    logic [31:0] exp_esp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  logic [2:0]  cur_len;
  vec_t        vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_seq(input vec_t v);
    logic [31:0] off;
    @(negedge clk);
    esp              = v.esp;
    ss_base          = v.base;
    ss_limit         = v.limit;
    ss_cache         = '0;
    ss_cache[54]     = v.db;
    ss_cache[43]     = v.code;
    ss_cache[42]     = v.ed;
    pop_count        = v.count;
    pop_length_word  = v.word;
    pop_length_dword = v.dword;
    operand_16bit    = v.op16;
    pop_start        = 1'b1;
    cur_len = v.word ? 3'd2 : (v.dword ? 3'd4 : (v.op16 ? 3'd2 : 3'd4));
    off = v.db ? v.esp : {16'h0000, v.esp[15:0]};
    for (int i = 0; i < v.n_reads; i++) begin
      addr_q.push_back(v.base + off);
      off = off + {29'd0, cur_len};
      if (!v.db) off = {16'h0000, off[15:0]};
    end
  endtask

  task automatic monitor(input vec_t v, input string tag);
    bit finished = 0;
    bit req_active = 0;
    bit first_req = 1;
    int wait_n = 0;
    logic [2:0] exp_idx = 3'd0;
    for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
      @(negedge clk);
      rd_done = 1'b0;
      if (cyc == 0 && v.restart) begin
        esp       = 32'h8000;
        pop_count = 3'd0;
        pop_start = 1'b1;
      end else begin
        pop_start = 1'b0;
      end
      if (pop_data_valid) begin
        if (data_q.size() == 0) chk({tag, "_extra_valid"}, 32'd1, 32'd0);
        else chk({tag, "_pop_data"}, pop_data, data_q.pop_front());
        chk({tag, "_pop_index"}, {29'd0, pop_index}, {29'd0, exp_idx});
        exp_idx++;
      end
      if (pop_done || pop_ss_fault) begin
        chk({tag, "_fault"}, {31'd0, pop_ss_fault}, {31'd0, v.exp_fault});
        chk({tag, "_new_esp"}, pop_new_esp, v.exp_esp);
        if (v.count == 3'd0) chk({tag, "_zero_lat"}, cyc, 0);
        finished = 1;
      end else if (rd_req) begin
        if (!req_active) begin
          req_active = 1;
          wait_n = $urandom_range(0, 2);
          if (first_req) chk({tag, "_first_req_lat"}, cyc, 1);
          first_req = 0;
          if (addr_q.size() == 0) chk({tag, "_unexpected_req"}, rd_linear, 32'hXXXX_XXXX);
          else chk({tag, "_rd_linear"}, rd_linear, addr_q.pop_front());
          chk({tag, "_rd_length"}, {29'd0, rd_length}, {29'd0, cur_len});
        end
        if (wait_n == 0) begin
          rd_done = 1'b1;
          rd_data = $urandom;
          data_q.push_back(cur_len == 3'd2 ? {16'h0000, rd_data[15:0]} : rd_data);
          req_active = 0;
        end else begin
          wait_n--;
        end
      end
    end
    if (!finished) chk({tag, "_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
    chk({tag, "_idle_after"}, {29'd0, pop_busy, pop_done, pop_ss_fault}, 32'd0);
    chk({tag, "_addr_left"}, addr_q.size(), 0);
    chk({tag, "_data_left"}, data_q.size(), 0);
    addr_q.delete();
    data_q.delete();
  endtask

  function automatic logic all_out_or();
    return |{rd_req, rd_linear, rd_length, pop_data, pop_data_valid, pop_index,
             pop_busy, pop_done, pop_ss_fault, pop_new_esp};
  endfunction

  initial begin
    //           db code ed esp            base       limit      cnt  w  d  o16 rs n  flt exp_esp
    vecs[0]  = '{1, 0, 0, 32'h0000_1000, 32'h1_0000, 32'hFFFF, 3'd3, 0, 0, 0, 0, 3, 0, 32'h0000_100C};
    vecs[1]  = '{0, 0, 0, 32'hABCD_FFFE, 32'h0,      32'hFFFF, 3'd2, 1, 0, 0, 0, 2, 0, 32'hABCD_0002};
    vecs[2]  = '{1, 0, 0, 32'h0000_1004, 32'h0,      32'h1006, 3'd2, 0, 0, 0, 0, 0, 1, 32'h0000_1004};
    vecs[3]  = '{1, 0, 1, 32'h0000_0FFC, 32'h0,      32'h0FFF, 3'd1, 0, 1, 0, 0, 0, 1, 32'h0000_0FFC};
    vecs[4]  = '{1, 0, 1, 32'h0000_2000, 32'h100,    32'h0FFF, 3'd1, 0, 1, 0, 0, 1, 0, 32'h0000_2004};
    vecs[5]  = '{1, 0, 0, 32'h0000_1234, 32'h0,      32'hFFFF, 3'd0, 0, 0, 0, 0, 0, 0, 32'h0000_1234};
    vecs[6]  = '{1, 0, 0, 32'h0000_0000, 32'h200,    32'hFFFF, 3'd7, 0, 1, 0, 0, 6, 0, 32'h0000_0018};
    vecs[7]  = '{1, 0, 0, 32'h0000_0010, 32'h0,      32'hFFFF, 3'd1, 0, 1, 1, 0, 1, 0, 32'h0000_0014};
    vecs[8]  = '{1, 0, 0, 32'h0000_0020, 32'h0,      32'hFFFF, 3'd2, 0, 0, 1, 0, 2, 0, 32'h0000_0024};
    vecs[9]  = '{1, 0, 0, 32'h0000_1000, 32'h0,      32'h1007, 3'd3, 0, 0, 0, 0, 2, 1, 32'h0000_1000};
    vecs[10] = '{1, 0, 0, 32'h0000_1000, 32'h0,      32'h1001, 3'd1, 1, 0, 0, 0, 1, 0, 32'h0000_1002};
    vecs[11] = '{1, 1, 1, 32'h0000_0500, 32'h0,      32'hFFFF, 3'd1, 0, 1, 0, 0, 1, 0, 32'h0000_0504};
    vecs[12] = '{0, 0, 1, 32'hFFFF_FFFE, 32'h0,      32'h0FFF, 3'd1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE};
    vecs[13] = '{1, 0, 0, 32'h0000_4000, 32'h0,      32'hFFFF, 3'd2, 0, 1, 0, 1, 2, 0, 32'h0000_4008};
    vecs[14] = '{1, 0, 0, 32'h0000_1000, 32'h0,      32'h1000, 3'd1, 1, 0, 0, 0, 0, 1, 32'h0000_1000};

    rst_n = 1'b0; pop_start = 1'b0; pop_abort = 1'b0; pop_count = '0;
    pop_length_word = 1'b0; pop_length_dword = 1'b0; operand_16bit = 1'b0;
    esp = '0; ss_cache = '0; ss_base = '0; ss_limit = '0; rd_done = 1'b0; rd_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {31'd0, all_out_or()}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      start_seq(vecs[i]);
      monitor(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort while the second element's read is pending.
    @(negedge clk);
    esp = 32'h3000; ss_base = '0; ss_limit = 32'hFFFF; ss_cache = '0; ss_cache[54] = 1'b1;
    pop_count = 3'd4; pop_length_word = 1'b0; pop_length_dword = 1'b1; pop_start = 1'b1;
    @(negedge clk); pop_start = 1'b0;
    @(negedge clk); chk("abort_req0", {31'd0, rd_req}, 32'd1);
    rd_done = 1'b1; rd_data = 32'h1111_2222;
    @(negedge clk); rd_done = 1'b0;
    chk("abort_valid0", {31'd0, pop_data_valid}, 32'd1);
    @(negedge clk);
    chk("abort_req1", {31'd0, rd_req}, 32'd1);
    chk("abort_req1_addr", rd_linear, 32'h3004);
    pop_abort = 1'b1;
    @(negedge clk); pop_abort = 1'b0;
    chk("abort_state", {28'd0, rd_req, pop_busy, pop_done, pop_ss_fault}, 32'd0);
    rd_done = 1'b1; rd_data = 32'hDEAD_BEEF;
    @(negedge clk); rd_done = 1'b0;
    chk("abort_late_done", {28'd0, pop_data_valid, pop_busy, pop_done, pop_ss_fault}, 32'd0);
    @(negedge clk);
    chk("abort_quiet", {29'd0, rd_req, pop_busy, pop_done}, 32'd0);

    // Reset in the middle of a sequence clears every output.
    esp = 32'h5000; pop_count = 3'd3; pop_start = 1'b1;
    @(negedge clk); pop_start = 1'b0;
    @(negedge clk); chk("rst_mid_req", {31'd0, rd_req}, 32'd1);
    rd_done = 1'b1; rd_data = 32'hCAFE_F00D;
    @(negedge clk); rd_done = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {31'd0, all_out_or()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle", {31'd0, pop_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
